// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared types, lengths and FSM state encoding for the memory controller.
// Exports ADDR/INST/DATA types, TRUE/FALSE, LEN_* codes, state_t and len_bytes().
// No ports; imported by memctrl_if and memctrl.
package memctrl_pkg;

  localparam int MC_ADDR_W = 32;
  localparam int MC_DATA_W = 32;

  typedef logic [MC_ADDR_W-1:0] addr_t;
  typedef logic [MC_DATA_W-1:0] inst_t;
  typedef logic [MC_DATA_W-1:0] data_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_READ  = 2'd1,
    LS_READ  = 2'd2,
    LS_WRITE = 2'd3
  } state_t;

  // Number of RAM bytes for an LSB length code; the reserved code 3 moves a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_bytes = 3'd1;
      LEN_HALF: len_bytes = 3'd2;
      LEN_WORD: len_bytes = 3'd4;
      default:  len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memctrl_if.sv
// memctrl_if: fetch request, LSB request and byte-wide RAM bus of the memory controller.
// Ports: none; slave modport is the controller's view, master is the requester/RAM side.
// Requests are level-held by the requesters; responses are one-cycle ready pulses.
interface memctrl_if;
  import memctrl_pkg::*;

  logic        if_to_mc_ready;
  addr_t       if_to_mc_PC;
  logic        mc_to_if_ready;
  inst_t       mc_to_if_inst;

  logic        lsb_to_mc_ready;
  logic        lsb_to_mc_wr;
  logic [1:0]  lsb_to_mc_len;
  addr_t       lsb_to_mc_addr;
  data_t       lsb_to_mc_data;
  logic        mc_to_lsb_ready;
  data_t       mc_to_lsb_data;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  addr_t       mem_a;
  logic        mem_wr;

  modport slave (
    input  if_to_mc_ready, if_to_mc_PC,
    input  lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_len, lsb_to_mc_addr, lsb_to_mc_data,
    input  mem_din,
    output mc_to_if_ready, mc_to_if_inst,
    output mc_to_lsb_ready, mc_to_lsb_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_to_mc_ready, if_to_mc_PC,
    output lsb_to_mc_ready, lsb_to_mc_wr, lsb_to_mc_len, lsb_to_mc_addr, lsb_to_mc_data,
    output mem_din,
    input  mc_to_if_ready, mc_to_if_inst,
    input  mc_to_lsb_ready, mc_to_lsb_data,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/memctrl.sv
// memctrl: arbitrates fetch vs LSB (LSB wins) and serialises each access onto a byte-wide sync RAM.
// Ports: clk_in, rst_in (async high), rdy_in (global hold), clr_in (flush), io_buffer_full; bus = memctrl_if.slave.
// Latency: read N+1 cycles after accept (word fetch 5), write N cycles; requests held until the ready pulse.
// Optional macro MEMCTRL_IO_STALL_EN: writes to addr[17:16]==2'b11 hold their current byte while io_buffer_full.
module memctrl
  import memctrl_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clr_in,
  input  logic     io_buffer_full,
  memctrl_if.slave bus
);

  state_t            state_q, state_nx;
  logic [2:0]        cnt_q, cnt_nx, len_q, len_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx, mem_a_q, mem_a_nx;
  logic [DATA_W-1:0] wdat_q, wdat_nx, buf_q, buf_nx;
  logic [DATA_W-1:0] inst_q, inst_nx, ldat_q, ldat_nx;
  logic [7:0]        dout_q, dout_nx;
  logic              wr_q, wr_nx, if_rdy_q, if_rdy_nx, lsb_rdy_q, lsb_rdy_nx;
  logic              stall;
  logic [2:0]        nxt;
  logic [1:0]        sidx;
  logic [DATA_W-1:0] smp;

`ifdef MEMCTRL_IO_STALL_EN
  assign stall = (state_q == LS_WRITE) && (addr_q[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign stall     = 1'b0;
`endif

  // cnt counts edges since accept; the byte arriving on mem_din belongs to cnt-1
  // because the RAM adds one cycle of registered read latency.
  assign nxt  = cnt_q + 3'd1;
  assign sidx = cnt_q[1:0] - 2'd1;

  always_comb begin
    smp = buf_q;
    smp[8*sidx +: 8] = bus.mem_din;
  end

  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    len_nx     = len_q;
    addr_nx    = addr_q;
    wdat_nx    = wdat_q;
    buf_nx     = buf_q;
    mem_a_nx   = mem_a_q;
    dout_nx    = dout_q;
    wr_nx      = wr_q;
    inst_nx    = inst_q;
    ldat_nx    = ldat_q;
    if_rdy_nx  = FALSE;
    lsb_rdy_nx = FALSE;

    case (state_q)
      IDLE: begin
        wr_nx = FALSE;
        // A ready pulse still on the bus means the requester has not yet seen it;
        // accepting now would re-serve its stale request.
        if (!clr_in && !if_rdy_q && !lsb_rdy_q) begin
          if (bus.lsb_to_mc_ready) begin
            state_nx = bus.lsb_to_mc_wr ? LS_WRITE : LS_READ;
            len_nx   = len_bytes(bus.lsb_to_mc_len);
            addr_nx  = bus.lsb_to_mc_addr;
            wdat_nx  = bus.lsb_to_mc_data;
            mem_a_nx = bus.lsb_to_mc_addr;
            dout_nx  = bus.lsb_to_mc_data[7:0];
            wr_nx    = bus.lsb_to_mc_wr;
            cnt_nx   = 3'd0;
            buf_nx   = '0;
          end else if (bus.if_to_mc_ready) begin
            state_nx = IF_READ;
            len_nx   = 3'd4;
            addr_nx  = bus.if_to_mc_PC;
            mem_a_nx = bus.if_to_mc_PC;
            cnt_nx   = 3'd0;
            buf_nx   = '0;
          end
        end
      end

      IF_READ, LS_READ: begin
        if (clr_in) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
        end else if (cnt_q == len_q) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
          if (state_q == IF_READ) begin
            if_rdy_nx = TRUE;
            inst_nx   = smp;
          end else begin
            lsb_rdy_nx = TRUE;
            ldat_nx    = smp;
          end
        end else begin
          cnt_nx = nxt;
          if (cnt_q != 3'd0) buf_nx = smp;
          if (nxt < len_q) mem_a_nx = addr_q + ADDR_W'(nxt);
        end
      end

      LS_WRITE: begin
        // A write in flight always finishes its bytes; a flush only hides the done pulse.
        if (!stall) begin
          if (nxt < len_q) begin
            cnt_nx   = nxt;
            mem_a_nx = addr_q + ADDR_W'(nxt);
            dout_nx  = wdat_q[8*nxt[1:0] +: 8];
            wr_nx    = TRUE;
          end else begin
            state_nx   = IDLE;
            cnt_nx     = 3'd0;
            wr_nx      = FALSE;
            lsb_rdy_nx = !clr_in;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      buf_q     <= '0;
      mem_a_q   <= '0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      inst_q    <= '0;
      ldat_q    <= '0;
      if_rdy_q  <= 1'b0;
      lsb_rdy_q <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      len_q     <= len_nx;
      addr_q    <= addr_nx;
      wdat_q    <= wdat_nx;
      buf_q     <= buf_nx;
      mem_a_q   <= mem_a_nx;
      dout_q    <= dout_nx;
      wr_q      <= wr_nx;
      inst_q    <= inst_nx;
      ldat_q    <= ldat_nx;
      if_rdy_q  <= if_rdy_nx;
      lsb_rdy_q <= lsb_rdy_nx;
    end
  end

  assign bus.mem_a           = mem_a_q;
  assign bus.mem_dout        = dout_q;
  assign bus.mem_wr          = wr_q & ~stall;
  assign bus.mc_to_if_ready  = if_rdy_q;
  assign bus.mc_to_if_inst   = inst_q;
  assign bus.mc_to_lsb_ready = lsb_rdy_q;
  assign bus.mc_to_lsb_data  = ldat_q;

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: randomized and directed transactions against a transaction-level memory model.
// Drives requests #1 after each edge, samples #1 after each edge; RAM model is a registered byte RAM.
// Ends with one summary line; all comparisons go through chk().
module tb_memctrl;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clr_in = 1'b0;
  logic io_buffer_full = 1'b0;

  int checks = 0;
  int errors = 0;

  memctrl_if bus();

  memctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clr_in         (clr_in),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  always #5 clk_in = ~clk_in;

  // Physical RAM contents (written only by the DUT) and the reference view of memory.
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  always @(posedge clk_in) begin
    if (rdy_in) begin
      bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : init_byte(bus.mem_a);
      if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]    = b;
    shadow[a] = b;
  endtask

  task automatic drop_reqs();
    bus.if_to_mc_ready  = 1'b0;
    bus.lsb_to_mc_ready = 1'b0;
  endtask

  // Wait for the ready pulse of one requester; lat = index of the edge (0 = first edge waited).
  task automatic wait_pls(input int kind, input int max, output int lat, output logic [31:0] dat);
    lat = -1;
    dat = '0;
    for (int c = 0; c < max && lat < 0; c++) begin
      tick();
      if ((kind == 0) ? bus.mc_to_if_ready : bus.mc_to_lsb_ready) begin
        lat = c;
        dat = (kind == 0) ? bus.mc_to_if_inst : bus.mc_to_lsb_data;
      end
    end
  endtask

  // Count pulses of either requester over n cycles.
  task automatic quiet(input int n, output int seen);
    seen = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (bus.mc_to_if_ready || bus.mc_to_lsb_ready) seen++;
    end
  endtask

  // One transaction issued with the controller idle. kind: 0 fetch, 1 load, 2 store.
  task automatic xact(input int kind, input logic [31:0] a, input logic [1:0] len,
                      input logic [31:0] wd);
    int n, lat;
    logic [31:0] expd, got;
    logic p;
    n    = (kind == 0) ? 4 : nbytes(len);
    expd = '0;
    for (int k = 0; k < n; k++) expd[8*k +: 8] = sh_rd(a + k);
    if (kind == 2) for (int k = 0; k < n; k++) shadow[a + k] = wd[8*k +: 8];
    if (kind == 0) begin
      bus.if_to_mc_ready = 1'b1;
      bus.if_to_mc_PC    = a;
    end else begin
      bus.lsb_to_mc_ready = 1'b1;
      bus.lsb_to_mc_wr    = (kind == 2);
      bus.lsb_to_mc_len   = len;
      bus.lsb_to_mc_addr  = a;
      bus.lsb_to_mc_data  = wd;
    end
    lat = -1;
    got = '0;
    for (int c = 0; c < 16 && lat < 0; c++) begin
      tick();
      if (c < n) begin
        chk("mem_a", bus.mem_a, a + c);
        if (kind == 2) begin
          chk("mem_wr", {31'b0, bus.mem_wr}, 32'd1);
          chk("mem_dout", {24'b0, bus.mem_dout}, {24'b0, wd[8*c +: 8]});
        end
      end
      p = (kind == 0) ? bus.mc_to_if_ready : bus.mc_to_lsb_ready;
      if (p) begin
        lat = c;
        got = (kind == 0) ? bus.mc_to_if_inst : bus.mc_to_lsb_data;
      end
    end
    drop_reqs();
    chk("latency", lat, (kind == 2) ? n : n + 1);
    if (kind == 2) chk("wr_end", {31'b0, bus.mem_wr}, 32'd0);
    else           chk("rdata", got, expd);
    tick();
    p = (kind == 0) ? bus.mc_to_if_ready : bus.mc_to_lsb_ready;
    chk("pulse_w", {31'b0, p}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int lc, fc, lat, seen;
    logic [31:0] ld, fd, d;
    drop_reqs();
    bus.if_to_mc_PC    = '0;
    bus.lsb_to_mc_wr   = 1'b0;
    bus.lsb_to_mc_len  = '0;
    bus.lsb_to_mc_addr = '0;
    bus.lsb_to_mc_data = '0;
    bus.mem_din        = '0;

    #12;
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("rst_if_rdy", {31'b0, bus.mc_to_if_ready}, 32'd0);
    chk("rst_lsb_rdy", {31'b0, bus.mc_to_lsb_ready}, 32'd0);
    chk("rst_inst", bus.mc_to_if_inst, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    tick();

    // Fetch of addi a0,x0,0 at 0x1000.
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    xact(0, 32'h1000, 2'd0, 32'h0);
    chk("fetch_inst", bus.mc_to_if_inst, 32'h0000_0513);

    // LSB half load and fetch raised together: LSB first, fetch afterwards.
    preload(32'h2002, 8'h34); preload(32'h2003, 8'h12);
    bus.lsb_to_mc_ready = 1'b1; bus.lsb_to_mc_wr = 1'b0;
    bus.lsb_to_mc_len = 2'd1;   bus.lsb_to_mc_addr = 32'h2002;
    bus.if_to_mc_ready = 1'b1;  bus.if_to_mc_PC = 32'h1000;
    lc = -1; fc = -1; ld = '0; fd = '0;
    for (int c = 0; c < 30 && fc < 0; c++) begin
      tick();
      if (bus.mc_to_lsb_ready && lc < 0) begin
        lc = c; ld = bus.mc_to_lsb_data; bus.lsb_to_mc_ready = 1'b0;
      end
      if (bus.mc_to_if_ready && fc < 0) begin
        fc = c; fd = bus.mc_to_if_inst; bus.if_to_mc_ready = 1'b0;
      end
    end
    drop_reqs();
    chk("both_lsb_lat", lc, 32'd3);
    chk("both_lsb_dat", ld, 32'h0000_1234);
    chk("both_if_after", {31'b0, fc > lc}, 32'd1);
    chk("both_if_dat", fd, 32'h0000_0513);
    tick(); tick();

    // Word store then read back; wrap-around of the 32-bit address space.
    xact(2, 32'h3000, 2'd2, 32'hDEAD_BEEF);
    xact(1, 32'h3000, 2'd2, 32'h0);
    xact(1, 32'hFFFF_FFFE, 2'd2, 32'h0);
    xact(2, 32'hFFFF_FFFF, 2'd1, 32'h0000_A55A);
    xact(1, 32'hFFFF_FFFF, 2'd3, 32'h0);

    // Flush in the second cycle of a fetch: no pulse, then a clean fetch.
    bus.if_to_mc_ready = 1'b1; bus.if_to_mc_PC = 32'h1000;
    tick(); tick();
    clr_in = 1'b1; bus.if_to_mc_ready = 1'b0;
    tick();
    clr_in = 1'b0;
    quiet(8, seen);
    chk("clr_if_nopulse", seen, 32'd0);
    xact(0, 32'h2000, 2'd0, 32'h0);

    // Flush aborts a load.
    bus.lsb_to_mc_ready = 1'b1; bus.lsb_to_mc_wr = 1'b0;
    bus.lsb_to_mc_len = 2'd2;   bus.lsb_to_mc_addr = 32'h3000;
    tick(); tick();
    clr_in = 1'b1; drop_reqs();
    tick();
    clr_in = 1'b0;
    quiet(8, seen);
    chk("clr_ld_nopulse", seen, 32'd0);

    // Flush on the completion edge of a store: bytes written, pulse hidden.
    for (int k = 0; k < 4; k++) shadow[32'h3100 + k] = 8'hC0 + 8'(k);
    bus.lsb_to_mc_ready = 1'b1; bus.lsb_to_mc_wr = 1'b1;
    bus.lsb_to_mc_len = 2'd2;   bus.lsb_to_mc_addr = 32'h3100;
    bus.lsb_to_mc_data = 32'hC3C2_C1C0;
    tick(); tick(); tick(); tick();
    clr_in = 1'b1; drop_reqs();
    tick();
    clr_in = 1'b0;
    quiet(6, seen);
    chk("clr_st_nopulse", seen, 32'd0);
    xact(1, 32'h3100, 2'd2, 32'h0);

    // Flush in IDLE delays acceptance by one edge.
    clr_in = 1'b1; bus.if_to_mc_ready = 1'b1; bus.if_to_mc_PC = 32'h1000;
    tick();
    clr_in = 1'b0;
    wait_pls(0, 12, lat, d);
    drop_reqs();
    chk("clr_idle_lat", lat, 32'd5);
    chk("clr_idle_dat", d, 32'h0000_0513);
    tick();

    // Request withdrawn before acceptance: nothing is served.
    clr_in = 1'b1;
    bus.lsb_to_mc_ready = 1'b1; bus.lsb_to_mc_wr = 1'b1;
    bus.lsb_to_mc_len = 2'd0;   bus.lsb_to_mc_addr = 32'h3000;
    tick();
    clr_in = 1'b0; drop_reqs();
    quiet(8, seen);
    chk("withdraw_nopulse", seen, 32'd0);

    // rdy_in low for three cycles stretches a fetch by three cycles.
    bus.if_to_mc_ready = 1'b1; bus.if_to_mc_PC = 32'h1000;
    tick(); tick();
    rdy_in = 1'b0;
    tick(); tick(); tick();
    rdy_in = 1'b1;
    wait_pls(0, 12, lat, d);
    drop_reqs();
    chk("hold_lat", lat, 32'd3);
    chk("hold_dat", d, 32'h0000_0513);
    tick();

    // Byte store to the IO window with the UART buffer full.
`ifdef MEMCTRL_IO_STALL_EN
    shadow[32'h0003_0000] = 8'h77;
    io_buffer_full = 1'b1;
    bus.lsb_to_mc_ready = 1'b1; bus.lsb_to_mc_wr = 1'b1;
    bus.lsb_to_mc_len = 2'd0;   bus.lsb_to_mc_addr = 32'h0003_0000;
    bus.lsb_to_mc_data = 32'h0000_0077;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("io_stall_wr", {31'b0, bus.mem_wr}, 32'd0);
      chk("io_stall_rdy", {31'b0, bus.mc_to_lsb_ready}, 32'd0);
    end
    io_buffer_full = 1'b0;
    #1;
    chk("io_release_wr", {31'b0, bus.mem_wr}, 32'd1);
    wait_pls(1, 8, lat, d);
    drop_reqs();
    chk("io_done_lat", lat, 32'd0);
    tick();
`else
    io_buffer_full = 1'b1;
    xact(2, 32'h0003_0000, 2'd0, 32'h0000_0077);
    io_buffer_full = 1'b0;
`endif
    xact(1, 32'h0003_0000, 2'd0, 32'h0);

    // Reset in the middle of a store.
    bus.lsb_to_mc_ready = 1'b1; bus.lsb_to_mc_wr = 1'b1;
    bus.lsb_to_mc_len = 2'd2;   bus.lsb_to_mc_addr = 32'h4000;
    bus.lsb_to_mc_data = 32'h1122_3344;
    tick(); tick();
    #2 rst_in = 1'b1;
    #1;
    chk("arst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("arst_mem_a", bus.mem_a, 32'd0);
    chk("arst_mem_dout", {24'b0, bus.mem_dout}, 32'd0);
    chk("arst_inst", bus.mc_to_if_inst, 32'd0);
    chk("arst_ldat", bus.mc_to_lsb_data, 32'd0);
    drop_reqs();
    tick(); tick();
    rst_in = 1'b0;
    quiet(6, seen);
    chk("arst_nopulse", seen, 32'd0);

    // Randomized traffic in a private region.
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a    = 32'h100 + $urandom_range(0, 255);
      if (kind == 0) a[1:0] = 2'b00;
      xact(kind, a, 2'($urandom_range(0, 3)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
